// File: rtl/phase_sweep_ctrl_pkg.sv
// Shared types and constants for the DSP phase sweep controller.
// No logic; no backpressure.
package phase_sweep_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST,
    ST_SETTLE,
    ST_DWELL,
    ST_CAPTURE,
    ST_NEXT,
    ST_DONE
  } state_t;

  localparam int N_PHASES          = 4;
  localparam int DEF_RST_CYCLES    = 4;
  localparam int DEF_SETTLE_CYCLES = 256;

endpackage

// File: rtl/phase_sweep_ctrl_sweep_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
// Load takes effect next cycle; no backpressure.
module sweep_timer #(
  parameter int NB = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [NB-1:0] load_val,
  output logic          expired
);

  logic [NB-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - NB'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/phase_sweep_ctrl.sv
// Sweeps the 4 DSP phases, measures BER per phase and parks the link on the best one.
// Outputs registered; one sweep = 4*(RST+SETTLE+dwell+2)+1 cycles; abort/reset win over everything.
module phase_sweep_ctrl
  import phase_sweep_ctrl_pkg::*;
#(
  parameter int NB_CNT        = 64,
  parameter int NB_DWELL      = 32,
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic                clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic                i_abort,
  input  logic [NB_DWELL-1:0] i_dwell,
  input  logic [NB_CNT-1:0]   i_ber_samp_I,
  input  logic [NB_CNT-1:0]   i_ber_samp_Q,
  input  logic [NB_CNT-1:0]   i_ber_error_I,
  input  logic [NB_CNT-1:0]   i_ber_error_Q,
  output logic [3:0]          o_rstn,
  output logic                o_enb_tx,
  output logic                o_enb_rx,
  output logic [1:0]          o_phase_sel,
  output logic                o_busy,
  output logic                o_done,
  output logic [1:0]          o_best_phase,
  output logic [NB_CNT:0]     o_best_err,
  output logic                o_no_sync
);

  localparam logic [NB_DWELL-1:0] RST_LOAD    = NB_DWELL'(RST_CYCLES - 1);
  localparam logic [NB_DWELL-1:0] SETTLE_LOAD = NB_DWELL'(SETTLE_CYCLES - 1);
  localparam logic [1:0]          LAST_PHASE  = 2'(N_PHASES - 1);

  state_t              state;
  logic [1:0]          phase;
  logic [NB_DWELL-1:0] dwell_q;
  logic [NB_CNT:0]     best_err_w;
  logic [1:0]          best_phase_w;
  logic                no_sync_w;

  logic                tmr_load;
  logic [NB_DWELL-1:0] tmr_val;
  logic                tmr_exp;

  logic [NB_CNT:0]     cap_samp;
  logic [NB_CNT:0]     cap_err;
  logic                cap_zero;

  // Timer is preloaded one state early so each timed state lasts exactly its count.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = RST_LOAD;
    case (state)
      ST_IDLE, ST_NEXT: tmr_load = 1'b1;
      ST_RST: begin
        tmr_load = tmr_exp;
        tmr_val  = SETTLE_LOAD;
      end
      ST_SETTLE: begin
        tmr_load = tmr_exp;
        tmr_val  = dwell_q - NB_DWELL'(1);
      end
      default: ;
    endcase
  end

  sweep_timer #(.NB(NB_DWELL)) u_timer (
    .clk      (clk),
    .rst      (i_rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_exp)
  );

  always_comb begin
    cap_samp = {1'b0, i_ber_samp_I} + {1'b0, i_ber_samp_Q};
    cap_zero = (cap_samp == '0);
    cap_err  = cap_zero ? '1 : ({1'b0, i_ber_error_I} + {1'b0, i_ber_error_Q});
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= ST_IDLE;
      phase        <= '0;
      dwell_q      <= NB_DWELL'(1);
      best_err_w   <= '1;
      best_phase_w <= '0;
      no_sync_w    <= 1'b0;
      o_rstn       <= '0;
      o_enb_tx     <= 1'b0;
      o_enb_rx     <= 1'b0;
      o_phase_sel  <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_best_phase <= '0;
      o_best_err   <= '1;
      o_no_sync    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (state != ST_IDLE && i_abort) begin
        state    <= ST_IDLE;
        o_busy   <= 1'b0;
        o_rstn   <= '0;
        o_enb_tx <= 1'b0;
        o_enb_rx <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (i_start && !i_abort) begin
              state        <= ST_RST;
              phase        <= '0;
              best_err_w   <= '1;
              best_phase_w <= '0;
              no_sync_w    <= 1'b0;
              dwell_q      <= (i_dwell == '0) ? NB_DWELL'(1) : i_dwell;
              o_busy       <= 1'b1;
              o_rstn       <= '0;
              o_enb_tx     <= 1'b0;
              o_enb_rx     <= 1'b0;
              o_phase_sel  <= '0;
            end
          end
          ST_RST: begin
            if (tmr_exp) begin
              state    <= ST_SETTLE;
              o_rstn   <= '1;
              o_enb_tx <= 1'b1;
              o_enb_rx <= 1'b1;
            end
          end
          ST_SETTLE: if (tmr_exp) state <= ST_DWELL;
          ST_DWELL:  if (tmr_exp) state <= ST_CAPTURE;
          ST_CAPTURE: begin
            state <= ST_NEXT;
            if (cap_zero) no_sync_w <= 1'b1;
            if (cap_err < best_err_w) begin
              best_err_w   <= cap_err;
              best_phase_w <= phase;
            end
          end
          ST_NEXT: begin
            if (phase == LAST_PHASE) begin
              state        <= ST_DONE;
              o_done       <= 1'b1;
              o_best_phase <= best_phase_w;
              o_best_err   <= best_err_w;
              o_no_sync    <= no_sync_w;
              o_phase_sel  <= best_phase_w;
            end else begin
              state       <= ST_RST;
              phase       <= phase + 2'd1;
              o_phase_sel <= phase + 2'd1;
              o_rstn      <= '0;
              o_enb_tx    <= 1'b0;
              o_enb_rx    <= 1'b0;
            end
          end
          ST_DONE: begin
            state  <= ST_IDLE;
            o_busy <= 1'b0;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_phase_sweep_ctrl.sv
// Directed bench for phase_sweep_ctrl: BER tables per phase, scoreboard of sweep results.
module tb_phase_sweep_ctrl;

  localparam int NB_CNT   = 64;
  localparam int NB_DWELL = 32;
  localparam int RC       = 4;
  localparam int SC       = 256;
  localparam logic [NB_CNT:0] ONES = '1;

  logic                clk = 1'b0;
  logic                i_rst, i_start, i_abort;
  logic [NB_DWELL-1:0] i_dwell;
  logic [NB_CNT-1:0]   i_ber_samp_I, i_ber_samp_Q, i_ber_error_I, i_ber_error_Q;
  logic [3:0]          o_rstn;
  logic                o_enb_tx, o_enb_rx, o_busy, o_done, o_no_sync;
  logic [1:0]          o_phase_sel, o_best_phase;
  logic [NB_CNT:0]     o_best_err;

  typedef struct packed {
    logic [1:0]      phase;
    logic [NB_CNT:0] err;
    logic            nosync;
  } res_t;

  res_t              exp_q[$];
  res_t              last;
  logic [NB_CNT-1:0] t_ei[4], t_eq[4], t_si[4], t_sq[4];
  int                checks = 0;
  int                failures = 0;

  phase_sweep_ctrl #(
    .NB_CNT(NB_CNT), .NB_DWELL(NB_DWELL), .RST_CYCLES(RC), .SETTLE_CYCLES(SC)
  ) dut (
    .clk(clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort), .i_dwell(i_dwell),
    .i_ber_samp_I(i_ber_samp_I), .i_ber_samp_Q(i_ber_samp_Q),
    .i_ber_error_I(i_ber_error_I), .i_ber_error_Q(i_ber_error_Q),
    .o_rstn(o_rstn), .o_enb_tx(o_enb_tx), .o_enb_rx(o_enb_rx), .o_phase_sel(o_phase_sel),
    .o_busy(o_busy), .o_done(o_done), .o_best_phase(o_best_phase),
    .o_best_err(o_best_err), .o_no_sync(o_no_sync)
  );

  initial forever #5 clk = ~clk;

  // Emulated DSP: counters follow whichever phase the controller selects.
  initial forever begin
    @(negedge clk);
    i_ber_error_I = t_ei[o_phase_sel];
    i_ber_error_Q = t_eq[o_phase_sel];
    i_ber_samp_I  = t_si[o_phase_sel];
    i_ber_samp_Q  = t_sq[o_phase_sel];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [NB_CNT:0] obs, input logic [NB_CNT:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic set_phase(input int p, input logic [NB_CNT-1:0] ei, input logic [NB_CNT-1:0] eq,
                           input logic [NB_CNT-1:0] si, input logic [NB_CNT-1:0] sq);
    t_ei[p] = ei; t_eq[p] = eq; t_si[p] = si; t_sq[p] = sq;
  endtask

  function automatic res_t model();
    res_t r;
    logic [NB_CNT:0] e, s;
    r.phase = 2'd0; r.err = ONES; r.nosync = 1'b0;
    for (int p = 0; p < 4; p++) begin
      s = {1'b0, t_si[p]} + {1'b0, t_sq[p]};
      e = {1'b0, t_ei[p]} + {1'b0, t_eq[p]};
      if (s == '0) begin
        e = ONES;
        r.nosync = 1'b1;
      end
      if (e < r.err) begin
        r.err = e;
        r.phase = 2'(p);
      end
    end
    return r;
  endfunction

  task automatic run_sweep(input logic [NB_DWELL-1:0] dwell, input bit poke_start, output int cyc);
    res_t r;
    int k;
    bit seen;
    exp_q.push_back(model());
    @(negedge clk); i_dwell = dwell; i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    chk("busy_rise", o_busy, 1);
    k = 0; seen = 1'b0;
    while (k < 6000 && !seen) begin
      @(negedge clk); k++;
      if (poke_start && k == 20) begin i_start = 1'b1; i_dwell = 32'd500; end
      if (poke_start && k == 21) i_start = 1'b0;
      if (k == 30) begin
        chk("hold_best_err", o_best_err, last.err);
        chk("hold_best_phase", o_best_phase, last.phase);
        chk("hold_no_sync", o_no_sync, last.nosync);
      end
      if (o_done === 1'b1) seen = 1'b1;
    end
    checks++;
    assert (seen) else begin
      failures++;
      $error("FAIL done_timeout observed=%0d expected=done", k);
    end
    cyc = k + 1;
    if (seen) begin
      r = exp_q.pop_front();
      chk("best_phase", o_best_phase, r.phase);
      chk("best_err", o_best_err, r.err);
      chk("no_sync", o_no_sync, r.nosync);
      last = r;
      @(negedge clk);
      chk("done_one_cycle", o_done, 0);
      chk("idle_busy", o_busy, 0);
      chk("idle_phase_sel", o_phase_sel, r.phase);
      chk("idle_enb_tx", o_enb_tx, 1);
      chk("idle_enb_rx", o_enb_rx, 1);
      chk("idle_rstn", o_rstn, 4'hF);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_rstn"}, o_rstn, 0);
    chk({tag, "_enb_tx"}, o_enb_tx, 0);
    chk({tag, "_enb_rx"}, o_enb_rx, 0);
    chk({tag, "_phase_sel"}, o_phase_sel, 0);
    chk({tag, "_best_phase"}, o_best_phase, 0);
    chk({tag, "_best_err"}, o_best_err, ONES);
    chk({tag, "_no_sync"}, o_no_sync, 0);
  endtask

  task automatic load_5_2_9_7();
    set_phase(0, 64'd3, 64'd2, 64'd1000, 64'd1000);
    set_phase(1, 64'd1, 64'd1, 64'd1000, 64'd1000);
    set_phase(2, 64'd4, 64'd5, 64'd1000, 64'd1000);
    set_phase(3, 64'd7, 64'd0, 64'd1000, 64'd1000);
  endtask

  initial begin
    int cyc, k, exp_cyc;
    bit seen_done;
    logic [NB_CNT:0] big;
    big = {1'b1, 64'hFFFF_FFFF_FFFF_FFFE};

    i_rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_dwell = '0;
    for (int p = 0; p < 4; p++) set_phase(p, 64'd0, 64'd0, 64'd0, 64'd0);
    last.phase = 2'd0; last.err = ONES; last.nosync = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    i_rst = 1'b0;

    load_5_2_9_7();
    run_sweep(32'd100, 1'b0, cyc);
    chk("s1_phase", o_best_phase, 1);
    chk("s1_err", o_best_err, 2);

    for (int p = 0; p < 4; p++) set_phase(p, 64'd2, 64'd1, 64'd50, 64'd50);
    run_sweep(32'd10, 1'b0, cyc);
    chk("tie_phase", o_best_phase, 0);
    chk("tie_err", o_best_err, 3);

    for (int p = 0; p < 4; p++) set_phase(p, '1, '1, 64'd7, 64'd7);
    run_sweep(32'd10, 1'b0, cyc);
    chk("ovf_err", o_best_err, big);

    set_phase(0, 64'd4, 64'd0, 64'd9, 64'd9);
    set_phase(1, 64'd3, 64'd3, 64'd9, 64'd9);
    set_phase(2, 64'd0, 64'd0, 64'd0, 64'd0);
    set_phase(3, 64'd8, 64'd0, 64'd9, 64'd9);
    run_sweep(32'd10, 1'b0, cyc);
    chk("nosync_flag", o_no_sync, 1);
    chk("nosync_phase", o_best_phase, 0);
    chk("nosync_err", o_best_err, 4);

    // Abort well inside the 100-cycle dwell of phase 1.
    load_5_2_9_7();
    @(negedge clk); i_dwell = 32'd100; i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    k = 0;
    while (k < 3000 && !(o_phase_sel === 2'd1 && o_rstn === 4'hF)) begin
      @(negedge clk); k++;
    end
    checks++;
    assert (k < 3000) else begin
      failures++;
      $error("FAIL abort_wait observed=%0d expected=phase1_settle", k);
    end
    repeat (SC + 50) @(negedge clk);
    i_abort = 1'b1;
    @(negedge clk); i_abort = 1'b0;
    chk("abort_busy", o_busy, 0);
    chk("abort_rstn", o_rstn, 0);
    chk("abort_enb_tx", o_enb_tx, 0);
    seen_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (o_done !== 1'b0) seen_done = 1'b1;
      @(negedge clk);
    end
    chk("abort_no_done", seen_done, 0);
    chk("abort_keep_phase", o_best_phase, last.phase);
    chk("abort_keep_err", o_best_err, last.err);
    chk("abort_keep_nosync", o_no_sync, last.nosync);

    i_abort = 1'b1; i_start = 1'b1;
    @(negedge clk); i_abort = 1'b0; i_start = 1'b0;
    chk("abort_start_busy", o_busy, 0);
    @(negedge clk);
    chk("abort_start_busy2", o_busy, 0);

    // Reset in the middle of phase-0 SETTLE.
    @(negedge clk); i_dwell = 32'd100; i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    k = 0;
    while (k < 100 && o_rstn !== 4'hF) begin
      @(negedge clk); k++;
    end
    checks++;
    assert (k < 100) else begin
      failures++;
      $error("FAIL settle_wait observed=%0d expected=settle", k);
    end
    repeat (10) @(negedge clk);
    i_rst = 1'b1;
    #1;
    check_reset_vals("midrst");
    @(negedge clk); i_rst = 1'b0;
    last.phase = 2'd0; last.err = ONES; last.nosync = 1'b0;

    // dwell=0 acts as 1; a start pulse mid-sweep must not re-latch dwell.
    load_5_2_9_7();
    run_sweep(32'd0, 1'b1, cyc);
    exp_cyc = 4 * (RC + SC + 1 + 2) + 1;
    checks++;
    assert (cyc >= exp_cyc - 1 && cyc <= exp_cyc + 1) else begin
      failures++;
      $error("FAIL sweep_cycles observed=%0d expected=%0d", cyc, exp_cyc);
    end
    chk("d0_phase", o_best_phase, 1);
    chk("sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/phase_sweep_ctrl.md
PHASE_SWEEP_CTRL -- requirements
Module: phase_sweep_ctrl

Interface
REQ-001 Parameter NB_CNT, default 64: width of each DSP BER counter.
REQ-002 Parameter NB_DWELL, default 32: width of the dwell-length input.
REQ-003 Parameter RST_CYCLES, default 4: number of cycles DSP reset is held per phase.
REQ-004 Parameter SETTLE_CYCLES, default 256: post-reset wait before dwell starts (BER sync time).
REQ-005 Port clk  in  1: single clock, all logic on rising edge.
REQ-006 Port i_rst  in  1: asynchronous, active-high reset.
REQ-007 Port i_start  in  1: start a sweep; honoured only in IDLE.
REQ-008 Port i_abort  in  1: abandon the sweep; honoured in every state.
REQ-009 Port i_dwell  in  NB_DWELL: measurement length in cycles per phase; latched on an accepted start.
REQ-010 Ports i_ber_samp_I, i_ber_samp_Q, i_ber_error_I, i_ber_error_Q  in  NB_CNT each: DSP BER counters.
REQ-011 Port o_rstn  out  4: DSP reset, active low, all 4 bits identical.
REQ-012 Ports o_enb_tx, o_enb_rx  out  1 each: DSP transmit and receive enables.
REQ-013 Port o_phase_sel  out  2: DSP phase selector.
REQ-014 Port o_busy  out  1: high while in any state other than IDLE.
REQ-015 Port o_done  out  1: one-cycle pulse when a sweep completes.
REQ-016 Ports o_best_phase  out  2, o_best_err  out  NB_CNT+1: sweep result.
REQ-017 Port o_no_sync  out  1: at least one phase captured zero samples.

Function
REQ-018 States SHALL be IDLE, RST, SETTLE, DWELL, CAPTURE, NEXT, DONE.
REQ-019 IDLE: start accepted (and abort low) -> RST, with phase=0, best_err=all-ones, no_sync=0; dwell latched, 0 treated as 1.
REQ-020 RST: o_rstn=0, enables=0, o_phase_sel=phase; exit to SETTLE after exactly RST_CYCLES cycles.
REQ-021 SETTLE: o_rstn=all-ones, enables=1; exit to DWELL after SETTLE_CYCLES cycles.
REQ-022 DWELL: enables=1; exit to CAPTURE after exactly the latched dwell count of cycles.
REQ-023 CAPTURE (1 cycle): err = i_ber_error_I + i_ber_error_Q, zero-extended to NB_CNT+1 bits with no overflow; samp = samp_I + samp_Q.
REQ-024 CAPTURE: samp==0 -> err forced to all-ones and no_sync set.
REQ-025 CAPTURE: err strictly less than best_err -> best_err=err, best_phase=phase; on a tie the lower phase is kept.
REQ-026 NEXT: phase<3 -> phase+1, go to RST; phase==3 -> DONE.
REQ-027 DONE (1 cycle): o_done=1, then IDLE.
REQ-028 After a sweep, IDLE SHALL hold o_phase_sel=best_phase, enables=1, o_rstn=all-ones, so the link runs on the chosen phase.
REQ-029 o_best_phase, o_best_err and o_no_sync update only at DONE; they hold the previous result during a sweep.
REQ-030 i_abort in any non-IDLE state -> IDLE next cycle, enables=0, o_rstn=0, results unchanged, no o_done.
REQ-031 i_abort and i_start together in IDLE: abort wins and no sweep starts.
REQ-032 i_start while busy is ignored; dwell is not re-latched.
REQ-033 All outputs are registered; o_busy rises on the cycle after start is sampled.

Reset
REQ-034 i_rst -> IDLE, phase=0, o_rstn=0, enables=0, o_phase_sel=0, o_busy=0, o_done=0, o_best_phase=0, o_best_err=all-ones, o_no_sync=0.
REQ-035 Reset asserted mid-sweep returns immediately to the REQ-034 values; no partial result is published.

Structure
REQ-036 A shared package holds the state encoding, the phase count (4) and the default RST_CYCLES/SETTLE_CYCLES constants.
REQ-037 One sub-module, sweep_timer: a loadable NB_DWELL-bit down-counter with an expiry flag, shared by the RST, SETTLE and DWELL states.

Verification
REQ-038 Scenario: dwell=100, error sums per phase 5/2/9/7 (samples nonzero) -> o_best_phase=1, o_best_err=2, o_done once, idle o_phase_sel=1.
REQ-039 Scenario: errors 3/3/3/3 -> o_best_phase=0 (tie rule).
REQ-040 Scenario: error_I=error_Q=2^64-1 -> o_best_err=2^65-2, no overflow.
REQ-041 Scenario: samples=0 on phase 2, errors 4/6/0/8 -> o_no_sync=1, o_best_phase=0.
REQ-042 Scenario: abort during DWELL of phase 1 -> IDLE next cycle, o_rstn=0, no o_done, previous results kept; i_rst mid-SETTLE -> REQ-034 values.
REQ-043 Scenario: dwell=0 -> each DWELL lasts 1 cycle; total sweep = 4*(RST_CYCLES+SETTLE_CYCLES+1+2)+1 cycles ±1, checked against the bench cycle count.
